// File: rtl/fifo_pkg.sv
// Shared definitions for the flexible synchronous FIFO family.
// Read-mode encodings and the count-port width helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy ranges over 0..depth inclusive, so one extra code is needed.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the FIFO control never exposes stale entries.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with STD/FWFT read modes, programmable
// almost-full/almost-empty flags, occupancy, high-water mark and sticky errors.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  prog_full,
  input  logic [CNT_WIDTH-1:0]  prog_full_thresh,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  prog_empty,
  input  logic [CNT_WIDTH-1:0]  prog_empty_thresh,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  max_count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [1:0]            err_sticky,
  input  logic                  err_clr
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  count_r, max_r;
  logic                  ovf_r, unf_r;
  logic [1:0]            sticky_r;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_ok, rd_ok, wr_rej, rd_rej;

  // Explicit wrap so non-power-of-two depths use every entry.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count_r == FULL_CNT);
  assign empty      = (count_r == '0);
  assign prog_full  = (count_r >= prog_full_thresh);
  assign prog_empty = (count_r <= prog_empty_thresh);

  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign wr_rej = wr_en && full;
  assign rd_rej = rd_en && empty;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Error pulses, sticky flags (set beats clear) and high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      sticky_r <= '0;
      max_r    <= '0;
    end else begin
      ovf_r    <= wr_rej;
      unf_r    <= rd_rej;
      sticky_r <= (err_clr ? 2'b00 : sticky_r) | {rd_rej, wr_rej};
      if (err_clr)              max_r <= count_r;
      else if (count_r > max_r) max_r <= count_r;
    end
  end

  assign count      = count_r;
  assign max_count  = max_r;
  assign overflow   = ovf_r;
  assign underflow  = unf_r;
  assign err_sticky = sticky_r;

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data  = ram_rdata;
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // Stage p1: registered read word and its one-cycle valid strobe.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_ok;
          if (rd_ok) rd_data_p1 <= ram_rdata;
        end
      end

      assign rd_data  = rd_data_p1;
      assign rd_valid = vld_p1;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO for datapath buffering between PSK modulator stages. Supports any depth (not only powers of two) and all DEPTH entries are usable. It adds a selectable read mode (standard registered read or first-word fall-through), runtime-programmable almost-full/almost-empty thresholds, an occupancy count, a high-water mark, and sticky error flags.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 10, number of storage entries, ≥2, any integer
- FWFT, 0, 0 = standard read (1-cycle latency, rd_valid strobe); 1 = first-word fall-through
- CNT_WIDTH, $clog2(DEPTH+1), derived, width of count/threshold/high-water ports
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_data  in  DATA_WIDTH  write word
- wr_en  in  1  write request
- full  out  1  count == DEPTH
- prog_full  out  1  count ≥ prog_full_thresh
- prog_full_thresh  in  CNT_WIDTH  almost-full threshold, sampled every cycle
- rd_en  in  1  read request (FWFT: acknowledge of presented head word)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  STD: strobe one cycle after accepted read; FWFT: equals !empty
- empty  out  1  count == 0
- prog_empty  out  1  count ≤ prog_empty_thresh
- prog_empty_thresh  in  CNT_WIDTH  almost-empty threshold, sampled every cycle
- count  out  CNT_WIDTH  current occupancy
- max_count  out  CNT_WIDTH  high-water mark since reset or err_clr
- overflow  out  1  one-cycle pulse, registered: write rejected previous cycle
- underflow  out  1  one-cycle pulse, registered: read rejected previous cycle
- err_sticky  out  2  {underflow seen, overflow seen}; held until err_clr
- err_clr  in  1  clears err_sticky and resets max_count to current count

## Operation
- Write accepted iff wr_en && !full; stores wr_data at wr_ptr, wr_ptr advances.
- Read accepted iff rd_en && !empty; rd_ptr advances.
- Pointers wrap explicitly DEPTH-1 → 0; no reliance on power-of-two rollover.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags full, empty, prog_full, prog_empty are combinational from the count register only; never from wr_en/rd_en.
- Simultaneous wr_en+rd_en when full: read accepted, write rejected (overflow). When empty: write accepted, read rejected (underflow). No bypass path.
- Rejected write leaves memory, wr_ptr, and count untouched.
- STD mode: accepted read loads mem[rd_ptr] into rd_data register; rd_valid=1 next cycle only; rd_data holds last value otherwise.
- FWFT mode: rd_data = mem[rd_ptr] whenever !empty; rd_valid = !empty; rd_data undefined while empty.
- max_count updates to count whenever count > max_count; err_clr loads max_count ← count.
- err_sticky bits set on the cycle overflow/underflow pulse asserts. Set wins over simultaneous err_clr.
- Threshold values > DEPTH are legal: prog_full never asserts; prog_empty stays 1.

## Timing
- Reset values: rd_data 0, rd_valid 0, count 0, max_count 0, overflow 0, underflow 0, err_sticky 0. Hence empty 1, full 0, prog_empty 1, prog_full = (prog_full_thresh == 0).
- Memory array is not reset; stale contents are never visible because empty gates reads.
- rst mid-operation discards all contents in one cycle; inputs during rst are ignored.
- Write → empty deasserts next cycle. FWFT: head word visible on rd_data in that same next cycle.
- STD: read latency 1 cycle (rd_en at edge N → rd_data/rd_valid valid after edge N+1).
- Full throughput: one write and one read per cycle sustained.

## Structure
- Shared package fifo_pkg: FIFO_MODE_STD=0, FIFO_MODE_FWFT=1, and function cnt_width(depth) = $clog2(depth+1).
- Sub-module sync_fifo_ram: simple dual-port array, one write port, asynchronous read port; top level adds the STD-mode output register.
- Top level holds pointers, count, flags, error, and high-water logic.

## Test plan
- Reset, then write 0x01..0x0A (DEPTH=10) → full=1 after 10th write, count=10. 11th write → overflow pulse next cycle, err_sticky=2'b01, count stays 10.
- From full, read 10 words (STD) → rd_data 0x01..0x0A on consecutive rd_valid strobes, empty=1 after last. Extra read → underflow pulse, err_sticky=2'b11.
- FWFT=1, write 0x5A to empty FIFO → next cycle empty=0, rd_valid=1, rd_data=0x5A with no rd_en.
- Thresholds full=7, empty=2; stream 25 words with simultaneous wr/rd at count 7 → count holds at 7, prog_full stays 1; pointer wrap verified by data ordering across index 9→0.
- Simultaneous wr_en+rd_en at count 0 and count 10 → accepted/rejected exactly per rules; max_count=10; err_clr at count 4 → max_count=4, err_sticky=0.
- Assert rst while count=6 → next cycle count=0, empty=1, rd_valid=0; subsequent write/read returns the new word.
